// File: rtl/v_ctx_rd_if.sv
// Port bundle for the context read engine: writer notifications, pop requests,
// SRAM read port and the response stream.
interface v_ctx_rd_if #(
   parameter int unsigned CONTEXT_N = 128,
   parameter int unsigned ENTRIES_N = 4,
   parameter int unsigned W         = 32
);
   localparam int unsigned CTX_W = $clog2(CONTEXT_N);
   localparam int unsigned PTR_W = $clog2(ENTRIES_N);
   localparam int unsigned AW    = CTX_W + PTR_W;

   logic             push_vld;
   logic [CTX_W-1:0] push_ctx;
   logic [CTX_W-1:0] qry_ctx;
   logic             qry_full;
   logic             pop_vld;
   logic [CTX_W-1:0] pop_ctx;
   logic             pop_rdy;
   logic             rd_en;
   logic [AW-1:0]    rd_addr;
   logic [W-1:0]     rd_data;
   logic             rsp_vld;
   logic [CTX_W-1:0] rsp_ctx;
   logic             rsp_empty;
   logic [W-1:0]     rsp_data;
   logic             rsp_rdy;
   logic             err_ovf;

   // Environment side: writer, pop requester, SRAM and response consumer.
   modport master (
      output push_vld, push_ctx, qry_ctx, pop_vld, pop_ctx, rd_data, rsp_rdy,
      input  qry_full, pop_rdy, rd_en, rd_addr, rsp_vld, rsp_ctx, rsp_empty, rsp_data, err_ovf
   );

   // Read engine side.
   modport slave (
      input  push_vld, push_ctx, qry_ctx, pop_vld, pop_ctx, rd_data, rsp_rdy,
      output qry_full, pop_rdy, rd_en, rd_addr, rsp_vld, rsp_ctx, rsp_empty, rsp_data, err_ovf
   );
endinterface

// File: rtl/v_ctx_rd.sv
// Read-side engine for the per-context entry store. Tracks occupancy and read
// pointers per context, issues SRAM reads for pops and returns entries in
// accept order through a 3-deep response FIFO.
module v_ctx_rd #(
   parameter int unsigned CONTEXT_N = 128,
   parameter int unsigned ENTRIES_N = 4,
   parameter int unsigned W         = 32
) (
   input logic       clk,
   input logic       rst,
   v_ctx_rd_if.slave bus
);
   localparam int unsigned CTX_W = $clog2(CONTEXT_N);
   localparam int unsigned PTR_W = $clog2(ENTRIES_N);
   localparam int unsigned CNT_W = $clog2(ENTRIES_N + 1);

   localparam logic [CNT_W-1:0] CntFull = CNT_W'(ENTRIES_N);
   localparam logic [1:0]       FifoLast = 2'd2;

   logic [CNT_W-1:0] count_q  [CONTEXT_N];
   logic [PTR_W-1:0] rd_ptr_q [CONTEXT_N];

   logic             s1_vld_q;
   logic [CTX_W-1:0] s1_ctx_q;
   logic             s1_empty_q;

   logic [CTX_W-1:0] f_ctx_q   [3];
   logic             f_empty_q [3];
   logic [W-1:0]     f_data_q  [3];
   logic [1:0]       f_wr_q;
   logic [1:0]       f_rd_q;
   logic [1:0]       occ_q;

   logic             err_ovf_q;

   logic [CNT_W-1:0] pop_cnt;
   logic [CNT_W-1:0] push_cnt;
   logic [2:0]       inflight;
   logic             accept;
   logic             ne;
   logic             inc;
   logic             dec;
   logic             same_ctx;
   logic             deq;

   // Stage 0: accept decision, occupancy lookups and SRAM read request.
   always_comb begin
      pop_cnt      = count_q[bus.pop_ctx];
      push_cnt     = count_q[bus.push_ctx];
      // Entries already accepted but not yet consumed bound further acceptance.
      inflight     = {1'b0, occ_q} + {2'b00, s1_vld_q};
      bus.pop_rdy  = rst & (inflight < 3'd3);
      accept       = bus.pop_vld & bus.pop_rdy;
      ne           = (pop_cnt != '0);
      dec          = accept & ne;
      inc          = bus.push_vld & (push_cnt != CntFull);
      same_ctx     = (bus.push_ctx == bus.pop_ctx);
      bus.rd_en    = dec;
      bus.rd_addr  = {bus.pop_ctx, rd_ptr_q[bus.pop_ctx]};
      bus.qry_full = (count_q[bus.qry_ctx] == CntFull);
      bus.err_ovf  = err_ovf_q;
   end

   // Response FIFO head drives the output stream.
   always_comb begin
      bus.rsp_vld   = rst & (occ_q != 2'd0);
      bus.rsp_ctx   = f_ctx_q[f_rd_q];
      bus.rsp_empty = f_empty_q[f_rd_q];
      bus.rsp_data  = f_data_q[f_rd_q];
      deq           = bus.rsp_vld & bus.rsp_rdy;
   end

   // Per-context occupancy and read pointers; a push and pop to the same context cancel.
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < int'(CONTEXT_N); i++) begin
            count_q[i]  <= '0;
            rd_ptr_q[i] <= '0;
         end
      end else begin
         if (inc && !(dec && same_ctx)) begin
            count_q[bus.push_ctx] <= push_cnt + CNT_W'(1);
         end
         if (dec && !(inc && same_ctx)) begin
            count_q[bus.pop_ctx] <= pop_cnt - CNT_W'(1);
         end
         if (dec) begin
            // Power-of-two depth: natural overflow wraps the pointer.
            rd_ptr_q[bus.pop_ctx] <= rd_ptr_q[bus.pop_ctx] + PTR_W'(1);
         end
      end
   end

   // Stage 1 register and overflow pulse.
   always_ff @(posedge clk) begin
      if (!rst) begin
         s1_vld_q   <= 1'b0;
         s1_ctx_q   <= '0;
         s1_empty_q <= 1'b0;
         err_ovf_q  <= 1'b0;
      end else begin
         s1_vld_q   <= accept;
         s1_ctx_q   <= bus.pop_ctx;
         s1_empty_q <= ~ne;
         err_ovf_q  <= bus.push_vld & (push_cnt == CntFull);
      end
   end

   // FIFO pointers and occupancy; reset drops any buffered responses.
   always_ff @(posedge clk) begin
      if (!rst) begin
         f_wr_q <= 2'd0;
         f_rd_q <= 2'd0;
         occ_q  <= 2'd0;
      end else begin
         if (s1_vld_q) begin
            f_wr_q <= (f_wr_q == FifoLast) ? 2'd0 : f_wr_q + 2'd1;
         end
         if (deq) begin
            f_rd_q <= (f_rd_q == FifoLast) ? 2'd0 : f_rd_q + 2'd1;
         end
         unique case ({s1_vld_q, deq})
            2'b10:   occ_q <= occ_q + 2'd1;
            2'b01:   occ_q <= occ_q - 2'd1;
            default: occ_q <= occ_q;
         endcase
      end
   end

   // FIFO storage captures stage-1 results; empty pops carry zero data.
   always_ff @(posedge clk) begin
      if (s1_vld_q) begin
         f_ctx_q[f_wr_q]   <= s1_ctx_q;
         f_empty_q[f_wr_q] <= s1_empty_q;
         f_data_q[f_wr_q]  <= s1_empty_q ? '0 : bus.rd_data;
      end
   end
endmodule

// File: tb/tb_v_ctx_rd.sv
// Bench for v_ctx_rd: directed scenarios plus a random run, with a scoreboard
// that predicts every response from a per-context queue model.
module tb_v_ctx_rd;
   localparam int NCTX = 128;
   localparam int NENT = 4;
   localparam int DW   = 32;
   localparam int CW   = 7;
   localparam int PW   = 2;
   localparam int AW   = CW + PW;

   typedef struct packed {
      logic [CW-1:0] ctx;
      logic          empty;
      logic [DW-1:0] data;
      int unsigned   cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   v_ctx_rd_if #(.CONTEXT_N(NCTX), .ENTRIES_N(NENT), .W(DW)) bus ();

   v_ctx_rd #(.CONTEXT_N(NCTX), .ENTRIES_N(NENT), .W(DW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   int tests = 0;
   int fails = 0;

   // SRAM model: write from the writer, registered read.
   logic [DW-1:0] mem [1 << AW];
   logic          sram_we = 1'b0;
   logic [AW-1:0] sram_wa = '0;
   logic [DW-1:0] sram_wd = '0;
   logic [PW-1:0] wptr [NCTX];

   initial bus.rd_data = '0;
   always @(posedge clk) begin
      if (sram_we) mem[sram_wa] <= sram_wd;
      if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr];
   end

   // Scoreboard state.
   logic [DW-1:0] mq [NCTX][$];
   exp_t          exp_q [$];
   exp_t          e_m;
   exp_t          h_m;
   logic          acc_m;
   logic          full_m;
   logic          vld_m;
   logic          ovf_exp = 1'b0;
   int unsigned   cyc = 0;
   int            rsp_cnt = 0;
   logic [DW-1:0] push_data = '0;

   always @(negedge clk) begin
      cyc++;
      if (!rst) begin
         tests++;
         if (bus.pop_rdy !== 1'b0 || bus.rd_en !== 1'b0 || bus.rsp_vld !== 1'b0) begin
            fails++;
            $display("FAIL reset_outputs: pop_rdy=%b rd_en=%b rsp_vld=%b want 0 0 0",
                     bus.pop_rdy, bus.rd_en, bus.rsp_vld);
         end
         for (int i = 0; i < NCTX; i++) mq[i].delete();
         exp_q.delete();
         ovf_exp = 1'b0;
      end else begin
         tests++;
         if (bus.err_ovf !== ovf_exp) begin
            fails++;
            $display("FAIL err_ovf: got %b want %b", bus.err_ovf, ovf_exp);
         end
         tests++;
         if (bus.qry_full !== (mq[bus.qry_ctx].size() == NENT)) begin
            fails++;
            $display("FAIL qry_full ctx %0d: got %b want %b", bus.qry_ctx, bus.qry_full,
                     mq[bus.qry_ctx].size() == NENT);
         end
         tests++;
         if (bus.pop_rdy !== (exp_q.size() < 3)) begin
            fails++;
            $display("FAIL pop_rdy: got %b want %b", bus.pop_rdy, exp_q.size() < 3);
         end
         vld_m = 1'b0;
         if (exp_q.size() != 0) vld_m = (cyc - exp_q[0].cyc) >= 2;
         tests++;
         if (bus.rsp_vld !== vld_m) begin
            fails++;
            $display("FAIL rsp_vld: got %b want %b", bus.rsp_vld, vld_m);
         end
         if (bus.rsp_vld && bus.rsp_rdy && exp_q.size() != 0) begin
            h_m = exp_q.pop_front();
            rsp_cnt++;
            tests++;
            if (bus.rsp_ctx !== h_m.ctx || bus.rsp_empty !== h_m.empty
                || bus.rsp_data !== h_m.data) begin
               fails++;
               $display("FAIL rsp_payload: got ctx=%0d empty=%b data=%h want ctx=%0d empty=%b data=%h",
                        bus.rsp_ctx, bus.rsp_empty, bus.rsp_data, h_m.ctx, h_m.empty, h_m.data);
            end
         end
         acc_m  = bus.pop_vld & bus.pop_rdy;
         full_m = (mq[bus.push_ctx].size() == NENT);
         e_m    = '0;
         if (acc_m) begin
            e_m.ctx = bus.pop_ctx;
            e_m.cyc = cyc;
            if (mq[bus.pop_ctx].size() == 0) begin
               e_m.empty = 1'b1;
            end else begin
               e_m.data = mq[bus.pop_ctx].pop_front();
            end
            exp_q.push_back(e_m);
         end
         tests++;
         if (bus.rd_en !== (acc_m && !e_m.empty)) begin
            fails++;
            $display("FAIL rd_en: got %b want %b", bus.rd_en, acc_m && !e_m.empty);
         end
         // Pop is modelled first: no bypass, and a pop never frees room for a push.
         ovf_exp = bus.push_vld && full_m;
         if (bus.push_vld && !full_m) mq[bus.push_ctx].push_back(push_data);
      end
   end

   // Values captured during the last step, before its clock edge.
   logic          s_acc;
   logic          s_rden;
   logic [AW-1:0] s_addr;
   logic          s_full;
   logic          s_ovf;
   logic          s_rdy;
   logic          s_vld;

   task automatic step(input logic pv, input int pc, input logic [DW-1:0] pd,
                       input logic ov, input int oc, input logic rr);
      bus.push_vld = pv;
      bus.push_ctx = CW'(pc);
      bus.qry_ctx  = CW'(pc);
      push_data    = pd;
      bus.pop_vld  = ov;
      bus.pop_ctx  = CW'(oc);
      bus.rsp_rdy  = rr;
      sram_we      = 1'b0;
      #1;
      if (pv && !bus.qry_full) begin
         sram_we = 1'b1;
         sram_wa = {CW'(pc), wptr[pc]};
         sram_wd = pd;
         wptr[pc] = wptr[pc] + PW'(1);
      end
      #1;
      s_acc  = ov & bus.pop_rdy;
      s_rden = bus.rd_en;
      s_addr = bus.rd_addr;
      s_full = bus.qry_full;
      s_ovf  = bus.err_ovf;
      s_rdy  = bus.pop_rdy;
      s_vld  = bus.rsp_vld;
      @(posedge clk);
      #1;
      bus.push_vld = 1'b0;
      bus.pop_vld  = 1'b0;
      sram_we      = 1'b0;
   endtask

   task automatic do_reset(input int n);
      rst = 1'b0;
      bus.push_vld = 1'b0;
      bus.pop_vld  = 1'b0;
      sram_we      = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
      for (int i = 0; i < NCTX; i++) wptr[i] = '0;
      rst = 1'b1;
   endtask

   task automatic idle(input int n);
      repeat (n) step(1'b0, 0, '0, 1'b0, 0, 1'b1);
   endtask

   task automatic test_reset();
      rst = 1'b0;
      bus.pop_vld = 1'b1;
      bus.pop_ctx = '0;
      for (int i = 0; i < NCTX; i++) wptr[i] = '0;
      repeat (3) begin
         @(posedge clk);
         #3;
         tests++;
         if (bus.pop_rdy !== 1'b0 || bus.rd_en !== 1'b0 || bus.rsp_vld !== 1'b0) begin
            fails++;
            $display("FAIL reset_hold: pop_rdy=%b rd_en=%b rsp_vld=%b want 0 0 0",
                     bus.pop_rdy, bus.rd_en, bus.rsp_vld);
         end
      end
      @(posedge clk);
      #1;
      rst = 1'b1;
      bus.pop_vld = 1'b0;
      #2;
      tests++;
      if (bus.pop_rdy !== 1'b1) begin
         fails++;
         $display("FAIL reset_release_pop_rdy: got %b want 1", bus.pop_rdy);
      end
      for (int c = 0; c < NCTX; c++) begin
         step(1'b0, c, '0, 1'b0, 0, 1'b1);
         tests++;
         if (s_full !== 1'b0) begin
            fails++;
            $display("FAIL reset_qry_full ctx %0d: got %b want 0", c, s_full);
         end
      end
   endtask

   task automatic test_ctx5();
      logic [AW-1:0] ea;
      int r0;
      for (int i = 0; i < 4; i++) step(1'b1, 5, 32'hA000_0000 + DW'(i), 1'b0, 0, 1'b1);
      r0 = rsp_cnt;
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 0, '0, 1'b1, 5, 1'b1);
         ea = {CW'(5), PW'(i)};
         tests++;
         if (!s_acc || !s_rden || s_addr !== ea) begin
            fails++;
            $display("FAIL ctx5_rd_addr %0d: got acc=%b rd_en=%b addr=%h want 1 1 %h",
                     i, s_acc, s_rden, s_addr, ea);
         end
      end
      step(1'b0, 0, '0, 1'b1, 5, 1'b1);
      tests++;
      if (!s_acc || s_rden !== 1'b0) begin
         fails++;
         $display("FAIL ctx5_empty_pop: got acc=%b rd_en=%b want 1 0", s_acc, s_rden);
      end
      idle(4);
      tests++;
      if (rsp_cnt - r0 != 5) begin
         fails++;
         $display("FAIL ctx5_rsp_count: got %0d want 5", rsp_cnt - r0);
      end
   endtask

   task automatic test_wrap_full();
      logic [AW-1:0] ea;
      for (int i = 0; i < 4; i++) step(1'b1, 9, 32'h9000_0000 + DW'(i), 1'b0, 0, 1'b1);
      step(1'b0, 9, '0, 1'b0, 0, 1'b1);
      tests++;
      if (s_full !== 1'b1) begin
         fails++;
         $display("FAIL ctx9_full: got %b want 1", s_full);
      end
      step(1'b1, 9, 32'hDEAD_BEEF, 1'b0, 0, 1'b1);
      step(1'b0, 9, '0, 1'b0, 0, 1'b1);
      tests++;
      if (s_ovf !== 1'b1 || s_full !== 1'b1) begin
         fails++;
         $display("FAIL ctx9_overflow: got err_ovf=%b full=%b want 1 1", s_ovf, s_full);
      end
      step(1'b0, 9, '0, 1'b0, 0, 1'b1);
      tests++;
      if (s_ovf !== 1'b0) begin
         fails++;
         $display("FAIL ctx9_ovf_pulse: got %b want 0", s_ovf);
      end
      step(1'b0, 9, '0, 1'b1, 9, 1'b1);
      step(1'b1, 9, 32'h9000_0004, 1'b0, 0, 1'b1);
      for (int i = 1; i < 5; i++) begin
         step(1'b0, 0, '0, 1'b1, 9, 1'b1);
         ea = {CW'(9), PW'(i % 4)};
         tests++;
         if (!s_rden || s_addr !== ea) begin
            fails++;
            $display("FAIL ctx9_wrap_addr %0d: got rd_en=%b addr=%h want 1 %h",
                     i, s_rden, s_addr, ea);
         end
      end
      idle(4);
   endtask

   task automatic test_same_cycle();
      logic [AW-1:0] ea;
      step(1'b1, 7, 32'h7777_0000, 1'b1, 7, 1'b1);
      tests++;
      if (!s_acc || s_rden !== 1'b0) begin
         fails++;
         $display("FAIL ctx7_no_bypass: got acc=%b rd_en=%b want 1 0", s_acc, s_rden);
      end
      step(1'b0, 0, '0, 1'b1, 7, 1'b1);
      ea = {CW'(7), PW'(0)};
      tests++;
      if (!s_rden || s_addr !== ea) begin
         fails++;
         $display("FAIL ctx7_read: got rd_en=%b addr=%h want 1 %h", s_rden, s_addr, ea);
      end
      idle(4);
   endtask

   task automatic test_backpressure();
      int accepts = 0;
      int r0;
      for (int i = 0; i < 4; i++) step(1'b1, 11, 32'hB000_0000 + DW'(i), 1'b0, 0, 1'b1);
      for (int i = 0; i < 5; i++) begin
         step(1'b0, 0, '0, 1'b1, 11, 1'b0);
         if (s_acc) accepts++;
      end
      tests++;
      if (accepts != 3 || s_rdy !== 1'b0) begin
         fails++;
         $display("FAIL bp_accepts: got %0d accepts pop_rdy=%b want 3 and 0", accepts, s_rdy);
      end
      r0 = rsp_cnt;
      idle(3);
      #1;
      tests++;
      if (rsp_cnt - r0 != 3 || bus.pop_rdy !== 1'b1) begin
         fails++;
         $display("FAIL bp_drain: got %0d responses pop_rdy=%b want 3 and 1",
                  rsp_cnt - r0, bus.pop_rdy);
      end
      step(1'b0, 0, '0, 1'b1, 11, 1'b1);
      idle(4);
   endtask

   task automatic test_reset_mid();
      int r0;
      step(1'b1, 3, 32'h3333_0000, 1'b0, 0, 1'b0);
      step(1'b0, 0, '0, 1'b1, 3, 1'b0);
      step(1'b0, 0, '0, 1'b1, 3, 1'b0);
      step(1'b0, 0, '0, 1'b0, 0, 1'b0);
      r0 = rsp_cnt;
      do_reset(2);
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 3, '0, 1'b0, 0, 1'b1);
         tests++;
         if (s_vld !== 1'b0 || s_full !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid_discard: got rsp_vld=%b full=%b want 0 0", s_vld, s_full);
         end
      end
      tests++;
      if (rsp_cnt != r0) begin
         fails++;
         $display("FAIL reset_mid_count: got %0d responses want %0d", rsp_cnt, r0);
      end
   endtask

   task automatic test_random();
      int n = 0;
      do_reset(2);
      for (int i = 0; i < 10000; i++) begin
         step(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), DW'($urandom),
              1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
              ($urandom_range(0, 3) != 0));
      end
      while (exp_q.size() != 0 && n < 20) begin
         idle(1);
         n++;
      end
      tests++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL random_drain: got %0d outstanding want 0", exp_q.size());
      end
   endtask

   initial begin
      bus.push_vld = 1'b0;
      bus.push_ctx = '0;
      bus.qry_ctx  = '0;
      bus.pop_vld  = 1'b0;
      bus.pop_ctx  = '0;
      bus.rsp_rdy  = 1'b1;
      test_reset();
      test_ctx5();
      test_wrap_full();
      test_same_cycle();
      test_backpressure();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
